msrv32_load_align_unit: RTL and testbench

- Parametrised, sequential successor to the combinational load unit in the msrv32 memory stage.
- Accepts one load request at a time and issues aligned bus beats on the data port, stalling on bus wait states.
- Extracts byte, halfword, word or doubleword data and applies sign or zero extension, then returns the result with a valid pulse.
- Splits misaligned loads into two beats when the optional feature is compiled in.

---
 rtl/msrv32_load_align_unit.sv | 131 +++++++++++++
 tb/tb_msrv32_load_align_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/msrv32_load_align_unit.sv
// msrv32_load_align_unit: sequential load unit issuing aligned bus beats, extracting and extending load data.
// Ports: ms_riscv32_mp_clk_in/ms_riscv32_mp_rst_in (sync active-low reset); load_req_in, load_unsigned_in,
//   load_size_in, load_addr_in (request, sampled when lu_ready_out=1); ms_riscv32_mp_dmaddr_out,
//   ms_riscv32_mp_dmreq_out, ms_riscv32_mp_dmdata_in, ahb_ready_in, ahb_resp_in (data bus beat);
//   lu_ready_out, lu_valid_out, lu_output_out, lu_err_out (result).
// Build option: MSRV32_LOAD_MISALIGN_SPLIT_EN splits loads crossing a beat boundary into two beats;
//   without it such loads complete immediately with an error.
module msrv32_load_align_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              ms_riscv32_mp_clk_in,
   input  logic              ms_riscv32_mp_rst_in,
   input  logic              load_req_in,
   input  logic              load_unsigned_in,
   input  logic [1:0]        load_size_in,
   input  logic [ADDR_W-1:0] load_addr_in,
   output logic [ADDR_W-1:0] ms_riscv32_mp_dmaddr_out,
   output logic              ms_riscv32_mp_dmreq_out,
   input  logic [XLEN-1:0]   ms_riscv32_mp_dmdata_in,
   input  logic              ahb_ready_in,
   input  logic              ahb_resp_in,
   output logic              lu_ready_out,
   output logic              lu_valid_out,
   output logic [XLEN-1:0]   lu_output_out,
   output logic              lu_err_out
);
   localparam int BYTES = XLEN / 8;
   localparam int OFFW  = $clog2(BYTES);
   typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;
   state_t            state, nxt;
   logic [ADDR_W-1:0] addr, base;
   logic [OFFW-1:0]   off;
   logic [1:0]        size;
   logic              uns, err, err_n, msb;
   logic [XLEN-1:0]   lo_buf, lo_n, hi_n, sh, mask, ext, out;
`ifdef MSRV32_LOAD_MISALIGN_SPLIT_EN
   logic [XLEN-1:0]   hi_buf;
`endif
   // true when the access runs past the end of its aligned beat
   function automatic logic crosses(input logic [OFFW-1:0] o, input logic [1:0] s);
      return (5'(o) + (5'd1 << s)) > 5'(BYTES);
   endfunction
   assign off  = addr[OFFW-1:0];
   assign base = {addr[ADDR_W-1:OFFW], OFFW'(0)};
   assign lu_ready_out  = state == IDLE;
   assign lu_valid_out  = state == RESP;
   assign lu_err_out    = lu_valid_out & err;
   assign lu_output_out = out;
   assign ms_riscv32_mp_dmreq_out  = state == BEAT1 || state == BEAT2;
   assign ms_riscv32_mp_dmaddr_out = state == BEAT1 ? base : state == BEAT2 ? base + ADDR_W'(BYTES) : '0;
   always_comb begin
      nxt   = state;
      err_n = err;
      lo_n  = lo_buf;
`ifdef MSRV32_LOAD_MISALIGN_SPLIT_EN
      hi_n  = hi_buf;
`else
      hi_n  = '0;
`endif
      case (state)
         IDLE: if (load_req_in) begin
            nxt   = BEAT1;
            err_n = 1'b0;
            if (load_size_in == 2'b11 && XLEN == 32) begin
               nxt   = RESP;
               err_n = 1'b1;
            end
`ifndef MSRV32_LOAD_MISALIGN_SPLIT_EN
            else if (crosses(load_addr_in[OFFW-1:0], load_size_in)) begin
               nxt   = RESP;
               err_n = 1'b1;
            end
`endif
         end
         BEAT1: if (ahb_ready_in) begin
            lo_n  = ms_riscv32_mp_dmdata_in;
            err_n = ahb_resp_in;
            nxt   = RESP;
`ifdef MSRV32_LOAD_MISALIGN_SPLIT_EN
            if (!ahb_resp_in && crosses(off, size)) nxt = BEAT2;
`endif
         end
`ifdef MSRV32_LOAD_MISALIGN_SPLIT_EN
         BEAT2: if (ahb_ready_in) begin
            hi_n  = ms_riscv32_mp_dmdata_in;
            err_n = ahb_resp_in;
            nxt   = RESP;
         end
`endif
         RESP:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end
   // extraction works on the buffers as they will be after this edge, so the result
   // can be registered on the same edge that enters RESP
   always_comb begin
      sh   = XLEN'({hi_n, lo_n} >> {off, 3'b000});
      msb  = size == 2'd0 ? sh[7] : size == 2'd1 ? sh[15] : size == 2'd2 ? sh[31] : sh[XLEN-1];
      mask = size == 2'd0 ? XLEN'(8'hFF) : size == 2'd1 ? XLEN'(16'hFFFF) :
             size == 2'd2 ? XLEN'(32'hFFFF_FFFF) : '1;
      ext  = (sh & mask) | ({XLEN{~uns & msb}} & ~mask);
   end
   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         state  <= IDLE;
         addr   <= '0;
         size   <= '0;
         uns    <= 1'b0;
         err    <= 1'b0;
         lo_buf <= '0;
`ifdef MSRV32_LOAD_MISALIGN_SPLIT_EN
         hi_buf <= '0;
`endif
         out    <= '0;
      end else begin
         state  <= nxt;
         err    <= err_n;
         lo_buf <= lo_n;
`ifdef MSRV32_LOAD_MISALIGN_SPLIT_EN
         hi_buf <= hi_n;
`endif
         if (state == IDLE && load_req_in) begin
            addr <= load_addr_in;
            size <= load_size_in;
            uns  <= load_unsigned_in;
         end
         if (nxt == RESP) out <= err_n ? '0 : ext;
      end
   end
endmodule

// File: tb/tb_msrv32_load_align_unit.sv
// tb_msrv32_load_align_unit: directed self-checking bench for msrv32_load_align_unit (XLEN=32).
module tb_msrv32_load_align_unit;
   logic        clk = 1'b0, rst = 1'b0;
   logic        req = 1'b0, uns = 1'b0, ready = 1'b0, resp = 1'b0;
   logic [1:0]  size = 2'd0;
   logic [31:0] addr = '0, data = '0;
   logic [31:0] dmaddr, result;
   logic        dmreq, lu_ready, valid, err;
   int checks = 0, errors = 0;

   msrv32_load_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
      .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
      .load_req_in(req), .load_unsigned_in(uns), .load_size_in(size), .load_addr_in(addr),
      .ms_riscv32_mp_dmaddr_out(dmaddr), .ms_riscv32_mp_dmreq_out(dmreq),
      .ms_riscv32_mp_dmdata_in(data), .ahb_ready_in(ready), .ahb_resp_in(resp),
      .lu_ready_out(lu_ready), .lu_valid_out(valid), .lu_output_out(result), .lu_err_out(err));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic u);
      addr = a; size = s; uns = u; req = 1'b1;
   endtask

   initial begin
      req = 1'b1;
      step(); step();
      chk("rst_ready", 32'(lu_ready), 32'd1);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_dmreq", 32'(dmreq), 32'd0);
      chk("rst_out", result, 32'h0);
      chk("rst_dmaddr", dmaddr, 32'h0);
      req = 1'b0; rst = 1'b1;
      step();
      // signed LB at 0x1002
      issue(32'h1002, 2'd0, 1'b0); ready = 1'b1; data = 32'h12F4_5678;
      step(); req = 1'b0;
      chk("lb_dmreq", 32'(dmreq), 32'd1);
      chk("lb_dmaddr", dmaddr, 32'h1000);
      chk("lb_busy", 32'(lu_ready), 32'd0);
      chk("lb_novalid", 32'(valid), 32'd0);
      step();
      chk("lb_valid", 32'(valid), 32'd1);
      chk("lb_out", result, 32'hFFFF_FFF4);
      chk("lb_err", 32'(err), 32'd0);
      chk("lb_dmreq_resp", 32'(dmreq), 32'd0);
      step();
      chk("lb_pulse", 32'(valid), 32'd0);
      chk("lb_ready", 32'(lu_ready), 32'd1);
      chk("lb_hold", result, 32'hFFFF_FFF4);
      // unsigned LBU at 0x1002
      issue(32'h1002, 2'd0, 1'b1);
      step(); req = 1'b0; step();
      chk("lbu_valid", 32'(valid), 32'd1);
      chk("lbu_out", result, 32'h0000_00F4);
      step();
      // signed LH at 0x1002 and unsigned LHU at 0x1000
      issue(32'h1002, 2'd1, 1'b0); data = 32'h8001_1234;
      step(); req = 1'b0; step();
      chk("lh_out", result, 32'hFFFF_8001);
      step();
      issue(32'h1000, 2'd1, 1'b1); data = 32'h8765_C321;
      step(); req = 1'b0; step();
      chk("lhu_out", result, 32'h0000_C321);
      step();
      // LW with three wait states; a request while busy must be ignored
      issue(32'h2000, 2'd2, 1'b0); ready = 1'b0; data = 32'hDEAD_BEEF;
      step();
      addr = 32'h5554;
      for (int i = 0; i < 3; i++) begin
         chk("lw_wait_dmreq", 32'(dmreq), 32'd1);
         chk("lw_wait_dmaddr", dmaddr, 32'h2000);
         chk("lw_wait_novalid", 32'(valid), 32'd0);
         step();
      end
      req = 1'b0; ready = 1'b1;
      chk("lw_last_dmaddr", dmaddr, 32'h2000);
      step();
      chk("lw_valid", 32'(valid), 32'd1);
      chk("lw_out", result, 32'hDEAD_BEEF);
      step();
      chk("lw_idle", 32'(lu_ready), 32'd1);
      chk("lw_no_queue", 32'(dmreq), 32'd0);
      // misaligned LH at 0x1003
      issue(32'h1003, 2'd1, 1'b0); data = 32'hAB34_5678;
      step(); req = 1'b0;
`ifdef MSRV32_LOAD_MISALIGN_SPLIT_EN
      chk("split_b1_dmaddr", dmaddr, 32'h1000);
      chk("split_b1_dmreq", 32'(dmreq), 32'd1);
      step(); data = 32'h0000_00CD;
      chk("split_b2_dmaddr", dmaddr, 32'h1004);
      chk("split_b2_novalid", 32'(valid), 32'd0);
      step();
      chk("split_valid", 32'(valid), 32'd1);
      chk("split_err", 32'(err), 32'd0);
      chk("split_out", result, 32'hFFFF_CDAB);
      step();
      // bus error on the second beat
      issue(32'h3002, 2'd2, 1'b0); data = 32'h1111_2222;
      step(); req = 1'b0; step(); resp = 1'b1;
      chk("b2err_dmaddr", dmaddr, 32'h3004);
      step(); resp = 1'b0;
      chk("b2err_valid", 32'(valid), 32'd1);
      chk("b2err_err", 32'(err), 32'd1);
      chk("b2err_out", result, 32'h0);
      step();
      chk("b2err_ready", 32'(lu_ready), 32'd1);
      // reset while waiting in the second beat
      issue(32'h1003, 2'd1, 1'b0);
      step(); req = 1'b0; step(); ready = 1'b0;
      chk("rstmid_in_b2", dmaddr, 32'h1004);
`else
      chk("mis_dmreq", 32'(dmreq), 32'd0);
      chk("mis_valid", 32'(valid), 32'd1);
      chk("mis_err", 32'(err), 32'd1);
      chk("mis_out", result, 32'h0);
      step();
      chk("mis_ready", 32'(lu_ready), 32'd1);
      chk("mis_dmreq_after", 32'(dmreq), 32'd0);
      // reset while waiting in the first beat
      issue(32'h2004, 2'd2, 1'b0); ready = 1'b0;
      step(); req = 1'b0;
      chk("rstmid_in_b1", dmaddr, 32'h2004);
`endif
      rst = 1'b0;
      step();
      chk("rstmid_ready", 32'(lu_ready), 32'd1);
      chk("rstmid_dmreq", 32'(dmreq), 32'd0);
      chk("rstmid_valid", 32'(valid), 32'd0);
      rst = 1'b1; ready = 1'b1;
      step();
      chk("rstmid_novalid", 32'(valid), 32'd0);
      // bus error on a single aligned beat
      issue(32'h3000, 2'd2, 1'b0); resp = 1'b1; data = 32'h1234_5678;
      step(); req = 1'b0; step(); resp = 1'b0;
      chk("b1err_valid", 32'(valid), 32'd1);
      chk("b1err_err", 32'(err), 32'd1);
      chk("b1err_out", result, 32'h0);
      step();
      chk("b1err_ready", 32'(lu_ready), 32'd1);
      // illegal doubleword size on a 32-bit unit
      issue(32'h4000, 2'd3, 1'b0);
      step(); req = 1'b0;
      chk("ld_dmreq", 32'(dmreq), 32'd0);
      chk("ld_valid", 32'(valid), 32'd1);
      chk("ld_err", 32'(err), 32'd1);
      step();
      chk("ld_pulse", 32'(valid), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
